// File: rtl/ysyx_23060332_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM state, ownership and
// the latched memory request payload.
package ysyx_23060332_mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_RSP  = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_RESET = '0;

  // Fetches are always reads, so write-side fields are forced to zero.
  function automatic mem_req_t ifu_fetch_req(input logic [ADDR_W-1:0] addr);
    mem_req_t r;
    r       = MEM_REQ_RESET;
    r.addr  = addr;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_23060332_mem_arbiter_rr_arb2.sv
// Two-way grant logic: valids plus last grant and mode to a one-hot grant.
// Purely combinational so it can be exercised on its own.
module ysyx_23060332_mem_arbiter_rr_arb2
  import ysyx_23060332_mem_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  input  owner_e     last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (ifu_valid_i && lsu_valid_i) begin
      // Fixed priority favours the LSU; round-robin favours whoever waited.
      if (ARB_MODE == 1 || last_grant_i == OWNER_IFU) begin
        grant_o[GNT_LSU] = 1'b1;
      end else begin
        grant_o[GNT_IFU] = 1'b1;
      end
    end else if (ifu_valid_i) begin
      grant_o[GNT_IFU] = 1'b1;
    end else if (lsu_valid_i) begin
      grant_o[GNT_LSU] = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Shares the single memory port between IFU and LSU with one outstanding
// transaction, response routing back to the owner and a sticky watchdog.
module ysyx_23060332_mem_arbiter
  import ysyx_23060332_mem_arbiter_pkg::*;
#(
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              timeout
);

  localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] TMO_HIT = (CNT_W+1)'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_grant_q, last_grant_d;
  mem_req_t         req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [1:0]       grant;
  logic             in_idle, in_req, in_rsp, busy;
  logic             ifu_hs, lsu_hs, accept;
  logic             owner_rsp_ready;
  logic [CNT_W:0]   cnt_inc;

  ysyx_23060332_mem_arbiter_rr_arb2 #(
    .ARB_MODE (ARB_MODE)
  ) u_rr_arb2 (
    .ifu_valid_i  (ifu_req_valid),
    .lsu_valid_i  (lsu_req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign in_idle = (state_q == ARB_IDLE);
  assign in_req  = (state_q == ARB_REQ);
  assign in_rsp  = (state_q == ARB_RSP);
  assign busy    = in_req || in_rsp;

  assign ifu_hs  = in_idle && grant[GNT_IFU] && ifu_req_valid;
  assign lsu_hs  = in_idle && grant[GNT_LSU] && lsu_req_valid;
  assign accept  = ifu_hs || lsu_hs;

  assign owner_rsp_ready = (owner_q == OWNER_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
  assign cnt_inc         = {1'b0, cnt_q} + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (accept)                         state_d = ARB_REQ;
      ARB_REQ:  if (mem_req_ready)                  state_d = ARB_RSP;
      ARB_RSP:  if (mem_rsp_valid && mem_rsp_ready) state_d = ARB_IDLE;
      default:                                      state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready = in_idle && grant[GNT_IFU];
    lsu_req_ready = in_idle && grant[GNT_LSU];
    mem_req_valid = in_req;
    mem_rsp_ready = in_rsp && owner_rsp_ready;
    ifu_rsp_valid = in_rsp && (owner_q == OWNER_IFU) && mem_rsp_valid;
    lsu_rsp_valid = in_rsp && (owner_q == OWNER_LSU) && mem_rsp_valid;
    ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
    lsu_rdata     = lsu_rsp_valid ? mem_rdata : '0;
  end

  // Payload capture, ownership and watchdog.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;

    if (lsu_hs) begin
      owner_d      = OWNER_LSU;
      last_grant_d = OWNER_LSU;
      req_d        = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
    end else if (ifu_hs) begin
      owner_d      = OWNER_IFU;
      last_grant_d = OWNER_IFU;
      req_d        = ifu_fetch_req(ifu_addr);
    end

    if (accept) begin
      cnt_d = '0;
    end else if (busy) begin
      if (!(&cnt_q)) cnt_d = cnt_inc[CNT_W-1:0];
      // Raised on the same edge the counter reaches TIMEOUT_CYCLES-1.
      if (cnt_inc == TMO_HIT) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWNER_IFU;
      last_grant_q <= OWNER_IFU;
      req_q        <= MEM_REQ_RESET;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wen   = req_q.wen;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Bench for the memory arbiter: two instances (round-robin and LSU priority)
// share stimulus and are each compared against a transaction-level model.
module tb_ysyx_23060332_mem_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ifu_req_valid, ifu_rsp_ready, lsu_req_valid, lsu_wen, lsu_rsp_ready;
  logic        mem_req_ready, mem_rsp_valid;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_wmask;

  logic        ifu_req_ready [2];
  logic        ifu_rsp_valid [2];
  logic        lsu_req_ready [2];
  logic        lsu_rsp_valid [2];
  logic        mem_req_valid [2];
  logic        mem_wen       [2];
  logic        mem_rsp_ready [2];
  logic        timeout       [2];
  logic [31:0] ifu_rdata     [2];
  logic [31:0] lsu_rdata     [2];
  logic [31:0] mem_addr      [2];
  logic [31:0] mem_wdata     [2];
  logic [3:0]  mem_wmask     [2];

  ysyx_23060332_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready[0]), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid[0]), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata[0]),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready[0]), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid[0]), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata[0]),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr[0]),
    .mem_wen(mem_wen[0]), .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready[0]), .mem_rdata(mem_rdata),
    .timeout(timeout[0])
  );

  ysyx_23060332_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready[1]), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid[1]), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata[1]),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready[1]), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid[1]), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata[1]),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr[1]),
    .mem_wen(mem_wen[1]), .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready[1]), .mem_rdata(mem_rdata),
    .timeout(timeout[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model, one per instance: an optional pending transaction
  // (owner + payload), whether memory has taken it, its age and the flag.
  bit          m_pending [2];
  bit          m_taken   [2];
  int          m_owner   [2];   // 0 = IFU, 1 = LSU
  int          m_last    [2];
  int          m_age     [2];
  bit          m_tmo     [2];
  logic [31:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic        m_wen     [2];
  logic [3:0]  m_wmask   [2];

  typedef struct packed {
    logic iv, lv;
    logic ir0, lr0, ir1, lr1;
  } gvec_t;
  gvec_t gtab [4];

  task automatic chk1(input string nm, input int d, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %b, want %b", nm, d, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, want %h", nm, d, act, exp);
    end
  endtask

  function automatic int winner(input int d);
    if (ifu_req_valid && lsu_req_valid) return (d == 1) ? 1 : 1 - m_last[d];
    if (ifu_req_valid) return 0;
    if (lsu_req_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pending[d] = 0; m_taken[d] = 0; m_owner[d] = 0; m_last[d] = 0;
      m_age[d] = 0; m_tmo[d] = 0;
      m_addr[d] = '0; m_wdata[d] = '0; m_wen[d] = 1'b0; m_wmask[d] = '0;
    end
  endtask

  task automatic check_outputs();
    #1;
    for (int d = 0; d < 2; d++) begin
      int  w;
      bit  rsp_ifu, rsp_lsu;
      w       = m_pending[d] ? -1 : winner(d);
      rsp_ifu = m_pending[d] && m_taken[d] && (m_owner[d] == 0);
      rsp_lsu = m_pending[d] && m_taken[d] && (m_owner[d] == 1);
      chk1 ("ifu_req_ready", d, ifu_req_ready[d], w == 0);
      chk1 ("lsu_req_ready", d, lsu_req_ready[d], w == 1);
      chk1 ("mem_req_valid", d, mem_req_valid[d], m_pending[d] && !m_taken[d]);
      chk32("mem_addr",      d, mem_addr[d],      m_addr[d]);
      chk1 ("mem_wen",       d, mem_wen[d],       m_wen[d]);
      chk32("mem_wdata",     d, mem_wdata[d],     m_wdata[d]);
      chk32("mem_wmask",     d, {28'h0, mem_wmask[d]}, {28'h0, m_wmask[d]});
      chk1 ("mem_rsp_ready", d, mem_rsp_ready[d], (rsp_ifu && ifu_rsp_ready) || (rsp_lsu && lsu_rsp_ready));
      chk1 ("ifu_rsp_valid", d, ifu_rsp_valid[d], rsp_ifu && mem_rsp_valid);
      chk32("ifu_rdata",     d, ifu_rdata[d],     (rsp_ifu && mem_rsp_valid) ? mem_rdata : 32'h0);
      chk1 ("lsu_rsp_valid", d, lsu_rsp_valid[d], rsp_lsu && mem_rsp_valid);
      chk32("lsu_rdata",     d, lsu_rdata[d],     (rsp_lsu && mem_rsp_valid) ? mem_rdata : 32'h0);
      chk1 ("timeout",       d, timeout[d],       m_tmo[d]);
    end
  endtask

  // Advance the model across the rising edge using the inputs held there.
  task automatic commit();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!m_pending[d]) begin
        int w;
        w = winner(d);
        if (w >= 0) begin
          m_pending[d] = 1; m_taken[d] = 0; m_owner[d] = w; m_last[d] = w; m_age[d] = 0;
          if (w == 1) begin
            m_addr[d] = lsu_addr; m_wen[d] = lsu_wen; m_wdata[d] = lsu_wdata; m_wmask[d] = lsu_wmask;
          end else begin
            m_addr[d] = ifu_addr; m_wen[d] = 1'b0; m_wdata[d] = '0; m_wmask[d] = '0;
          end
        end
      end else begin
        if (m_age[d] < 1000) m_age[d]++;
        if (m_age[d] == TMO - 1) m_tmo[d] = 1;
        if (!m_taken[d]) begin
          if (mem_req_ready) m_taken[d] = 1;
        end else if (mem_rsp_valid && ((m_owner[d] == 0) ? ifu_rsp_ready : lsu_rsp_ready)) begin
          m_pending[d] = 0;
        end
      end
    end
  endtask

  task automatic zero_inputs();
    ifu_req_valid = 0; ifu_rsp_ready = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_rsp_ready = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    zero_inputs();
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got no finish, want finish before limit");
    $fatal(1, "time limit");
  end

  initial begin
    gtab[0] = '{iv: 0, lv: 0, ir0: 0, lr0: 0, ir1: 0, lr1: 0};
    gtab[1] = '{iv: 1, lv: 0, ir0: 1, lr0: 0, ir1: 1, lr1: 0};
    gtab[2] = '{iv: 0, lv: 1, ir0: 0, lr0: 1, ir1: 0, lr1: 1};
    gtab[3] = '{iv: 1, lv: 1, ir0: 0, lr0: 1, ir1: 0, lr1: 1};

    zero_inputs();
    model_reset();
    check_outputs();

    // Grant decisions straight out of reset; reset is re-applied before any edge.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst_n = 1;
      ifu_req_valid = gtab[i].iv;
      lsu_req_valid = gtab[i].lv;
      #1;
      chk1("grant_tab_ifu", 0, ifu_req_ready[0], gtab[i].ir0);
      chk1("grant_tab_lsu", 0, lsu_req_ready[0], gtab[i].lr0);
      chk1("grant_tab_ifu", 1, ifu_req_ready[1], gtab[i].ir1);
      chk1("grant_tab_lsu", 1, lsu_req_ready[1], gtab[i].lr1);
      rst_n = 0;
      ifu_req_valid = 0;
      lsu_req_valid = 0;
    end
    @(negedge clk);
    rst_n = 1;

    // IFU-only fetch, memory accepts after two wait cycles.
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; ifu_rsp_ready = 1;
    check_outputs();
    commit();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ifu_req_valid = 0; ifu_addr = 32'h1234_5678;
      check_outputs();
      chk32("fetch_addr", 0, mem_addr[0], 32'h8000_0000);
      chk1 ("fetch_wen",  0, mem_wen[0],  1'b0);
      chk32("fetch_mask", 0, {28'h0, mem_wmask[0]}, 32'h0);
      commit();
    end
    @(negedge clk);
    mem_req_ready = 1;
    check_outputs();
    commit();
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0010_0093;
    check_outputs();
    chk32("fetch_rdata",   0, ifu_rdata[0], 32'h0010_0093);
    chk1 ("fetch_lsu_rsp", 0, lsu_rsp_valid[0], 1'b0);
    commit();
    @(negedge clk);
    mem_rsp_valid = 0;
    check_outputs();
    commit();

    // Both masters continuously valid, zero-wait memory, four transactions.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004; ifu_rsp_ready = 1;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 1; lsu_wdata = 32'hCAFE_0000 + t;
        lsu_wmask = 4'hF; lsu_rsp_ready = 1;
        mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'hA5A5_0000 + t;
        check_outputs();
        chk1("prio_ifu_never_ready", 1, ifu_req_ready[1], 1'b0);
        if (c == 1) begin
          chk1 ("rr_alternate",   0, mem_wen[0], (t % 2) == 0);
          chk32("rr_alt_addr",    0, mem_addr[0], ((t % 2) == 0) ? 32'h8000_2000 : 32'h8000_0004);
          chk1 ("prio_lsu_wins",  1, mem_wen[1], 1'b1);
        end
        commit();
      end
    end

    // LSU store held off by memory for five cycles.
    @(negedge clk);
    ifu_req_valid = 0; mem_rsp_valid = 0; mem_req_ready = 0;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    check_outputs();
    commit();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lsu_req_valid = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      check_outputs();
      chk1 ("store_req_valid", 0, mem_req_valid[0], 1'b1);
      chk32("store_addr",      0, mem_addr[0], 32'h8000_1000);
      chk32("store_wdata",     0, mem_wdata[0], 32'hDEAD_BEEF);
      chk32("store_wmask",     0, {28'h0, mem_wmask[0]}, 32'h3);
      commit();
    end
    @(negedge clk);
    mem_req_ready = 1;
    check_outputs();
    commit();
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 0;
    check_outputs();
    chk1("store_rsp_wait", 0, lsu_rsp_valid[0], 1'b0);
    commit();
    @(negedge clk);
    mem_rsp_valid = 1; mem_rdata = 32'h0BAD_F00D;
    check_outputs();
    chk1("store_rsp_follow", 0, lsu_rsp_valid[0], 1'b1);
    commit();

    // Memory stalls the request; watchdog fires on the eighth cycle after REQ entry.
    do_reset();
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040; ifu_rsp_ready = 1;
    check_outputs();
    commit();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ifu_req_valid = 0;
      check_outputs();
      chk1("timeout_rise", 0, timeout[0], k >= TMO);
      chk1("timeout_rise", 1, timeout[1], k >= TMO);
      commit();
    end
    @(negedge clk);
    mem_req_ready = 1;
    check_outputs();
    commit();
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1111_2222;
    check_outputs();
    commit();
    @(negedge clk);
    mem_rsp_valid = 0;
    check_outputs();
    chk1("timeout_sticky", 0, timeout[0], 1'b1);
    chk1("idle_after_late", 0, mem_req_valid[0], 1'b0);
    commit();

    // Reset asserted while the LSU response is being delivered.
    @(negedge clk);
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000; lsu_rsp_ready = 1; mem_req_ready = 1;
    check_outputs();
    commit();
    @(negedge clk);
    lsu_req_valid = 0;
    check_outputs();
    commit();
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
    check_outputs();
    #2 rst_n = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1 ("rst_lsu_rsp_valid", d, lsu_rsp_valid[d], 1'b0);
      chk32("rst_lsu_rdata",     d, lsu_rdata[d], 32'h0);
      chk1 ("rst_mem_rsp_ready", d, mem_rsp_ready[d], 1'b0);
      chk1 ("rst_mem_req_valid", d, mem_req_valid[d], 1'b0);
      chk32("rst_mem_addr",      d, mem_addr[d], 32'h0);
      chk1 ("rst_mem_wen",       d, mem_wen[d], 1'b0);
      chk32("rst_mem_wdata",     d, mem_wdata[d], 32'h0);
      chk32("rst_mem_wmask",     d, {28'h0, mem_wmask[d]}, 32'h0);
      chk1 ("rst_timeout",       d, timeout[d], 1'b0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    mem_rsp_valid = 1; mem_rdata = 32'hFFFF_0000;
    check_outputs();
    chk1("stray_rsp_ready", 0, mem_rsp_ready[0], 1'b0);
    chk1("stray_lsu_valid", 0, lsu_rsp_valid[0], 1'b0);
    chk1("stray_ifu_valid", 0, ifu_rsp_valid[0], 1'b0);
    commit();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ifu_req_valid = ($urandom_range(0, 2) != 0);
      ifu_addr      = $urandom;
      ifu_rsp_ready = ($urandom_range(0, 3) != 0);
      lsu_req_valid = ($urandom_range(0, 2) != 0);
      lsu_addr      = $urandom;
      lsu_wen       = 1'($urandom);
      lsu_wdata     = $urandom;
      lsu_wmask     = 4'($urandom);
      lsu_rsp_ready = ($urandom_range(0, 3) != 0);
      mem_req_ready = ($urandom_range(0, 1) != 0);
      mem_rsp_valid = ($urandom_range(0, 1) != 0);
      mem_rdata     = $urandom;
      check_outputs();
      commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
